// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce_edge block: FSM state encodings and
// default parameter values.
package debounce_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StStableLo = 2'b00;
    localparam state_t StWaitHi   = 2'b01;
    localparam state_t StStableHi = 2'b10;
    localparam state_t StWaitLo   = 2'b11;

    localparam int unsigned DefSyncStages     = 2;
    localparam int unsigned DefDebounceCycles = 4;
    localparam int unsigned DefCntW           = 8;

endpackage

// File: rtl/sync_ff_chain.sv
// N-stage flop synchronizer for asynchronous single-bit inputs; every stage
// clears on synchronous reset.
module sync_ff_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d};
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/debounce_edge.sv
// Synchronizes and debounces a raw input into a clean level, with one-cycle
// rise/fall pulses and a wrapping count of accepted edges.
module debounce_edge
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DefSyncStages,
    parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
    parameter int unsigned CNT_W           = DefCntW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             en,
    input  logic             clr_count,
    output logic             q,
    output logic             qb,
    output logic             rise,
    output logic             fall,
    output logic             busy,
    output logic [CNT_W-1:0] edge_count
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic s;

    state_t state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic q_q, q_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;
    logic busy_q, busy_d;
    logic [CNT_W-1:0] edge_count_q, edge_count_d;

    sync_ff_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (din),
        .q     (s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StStableLo;
            cnt_q        <= '0;
            q_q          <= 1'b0;
            rise_q       <= 1'b0;
            fall_q       <= 1'b0;
            busy_q       <= 1'b0;
            edge_count_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            q_q          <= q_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            busy_q       <= busy_d;
            edge_count_q <= edge_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (en) begin
            unique case (state_q)
                StStableLo: begin
                    if (s) begin
                        state_d = StWaitHi;
                        cnt_d   = CntW'(1);
                    end
                end
                StWaitHi: begin
                    if (!s) begin
                        state_d = StStableLo;
                        cnt_d   = '0;
                    end else if (cnt_q == CntMax) begin
                        state_d = StStableHi;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StStableHi: begin
                    if (!s) begin
                        state_d = StWaitLo;
                        cnt_d   = CntW'(1);
                    end
                end
                StWaitLo: begin
                    if (s) begin
                        state_d = StStableHi;
                        cnt_d   = '0;
                    end else if (cnt_q == CntMax) begin
                        state_d = StStableLo;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                default: begin
                    state_d = StStableLo;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        rise_d = en && (state_q == StWaitHi) && s && (cnt_q == CntMax);
        fall_d = en && (state_q == StWaitLo) && !s && (cnt_q == CntMax);
        q_d    = q_q;
        if (rise_d) begin
            q_d = 1'b1;
        end else if (fall_d) begin
            q_d = 1'b0;
        end
        busy_d = (state_d == StWaitHi) || (state_d == StWaitLo);
        // A clear wins over a same-cycle increment; the pulse itself is unaffected.
        edge_count_d = edge_count_q;
        if (clr_count) begin
            edge_count_d = '0;
        end else if (rise_d || fall_d) begin
            edge_count_d = edge_count_q + CNT_W'(1);
        end
    end

    assign q          = q_q;
    assign qb         = ~q_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign busy       = busy_q;
    assign edge_count = edge_count_q;

endmodule

// File: tb/tb_debounce_edge.sv
// Scoreboard bench for debounce_edge: expected outputs are queued with each
// driven cycle and compared one clock later.
module tb_debounce_edge;

    logic clk = 1'b0;
    logic reset, din, en, clr_count;
    logic q, qb, rise, fall, busy;
    logic [7:0] ec8;
    logic q_w, qb_w, rise_w, fall_w, busy_w;
    logic [1:0] ec2;

    typedef struct {
        bit   chk;
        logic q;
        logic rise;
        logic fall;
        logic busy;
        int   ec;
    } exp_t;

    exp_t exp_q[$];
    int   edges = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    debounce_edge #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .en         (en),
        .clr_count  (clr_count),
        .q          (q),
        .qb         (qb),
        .rise       (rise),
        .fall       (fall),
        .busy       (busy),
        .edge_count (ec8)
    );

    debounce_edge #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (2)
    ) dut_w (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .en         (en),
        .clr_count  (clr_count),
        .q          (q_w),
        .qb         (qb_w),
        .rise       (rise_w),
        .fall       (fall_w),
        .busy       (busy_w),
        .edge_count (ec2)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input bit chk, input logic eq, input logic er, input logic ef,
                                input logic eb, input int ec);
        exp_t x;
        x.chk  = chk;
        x.q    = eq;
        x.rise = er;
        x.fall = ef;
        x.busy = eb;
        x.ec   = ec;
        return x;
    endfunction

    task automatic tick(input string tag, input logic d, input logic e, input logic c,
                        input logic r, input exp_t x);
        exp_t y;
        din       = d;
        en        = e;
        clr_count = c;
        reset     = r;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        y = exp_q.pop_front();
        if (y.chk) begin
            check_eq({tag, " q"},    int'(q),    int'(y.q));
            check_eq({tag, " qb"},   int'(qb),   int'(!y.q));
            check_eq({tag, " rise"}, int'(rise), int'(y.rise));
            check_eq({tag, " fall"}, int'(fall), int'(y.fall));
            check_eq({tag, " busy"}, int'(busy), int'(y.busy));
            check_eq({tag, " ec8"},  int'(ec8),  y.ec % 256);
            check_eq({tag, " ec2"},  int'(ec2),  y.ec % 4);
            check_eq({tag, " q_w"},  int'(q_w),  int'(y.q));
        end
    endtask

    // din moves to lvl before edge 0; acceptance lands on edge 5 plus any frozen cycles.
    task automatic edge_run(input string name, input logic lvl, input int clr_at,
                            input int fs, input int nf);
        int   acc;
        logic e, c;
        acc = 5 + nf;
        for (int j = 0; j <= acc + 2; j++) begin
            e = !(nf > 0 && j >= fs && j < fs + nf);
            c = (j == clr_at);
            if (j == acc) edges = c ? 0 : edges + 1;
            else if (c) edges = 0;
            tick($sformatf("%s[%0d]", name, j), lvl, e, c, 1'b0,
                 mk(1'b1, (j >= acc) ? lvl : !lvl, lvl && (j == acc), !lvl && (j == acc),
                    (j >= 2) && (j < acc), edges));
        end
    endtask

    initial begin
        din       = 1'b0;
        en        = 1'b1;
        clr_count = 1'b0;
        reset     = 1'b1;

        for (int j = 0; j < 3; j++)
            tick($sformatf("reset[%0d]", j), 1'b0, 1'b1, 1'b0, 1'b1, mk(1'b1, 0, 0, 0, 0, 0));
        for (int j = 0; j < 20; j++)
            tick($sformatf("idle[%0d]", j), 1'b0, 1'b1, 1'b0, 1'b0, mk(1'b1, 0, 0, 0, 0, 0));

        edge_run("rise1", 1'b1, -1, 0, 0);
        edge_run("fall1", 1'b0, -1, 0, 0);
        edge_run("rise2", 1'b1, -1, 0, 0);
        edge_run("fall2", 1'b0, -1, 0, 0);
        edge_run("rise_clr", 1'b1, 5, 0, 0);
        edge_run("fall3", 1'b0, -1, 0, 0);

        for (int j = 0; j < 10; j++)
            tick($sformatf("glitch[%0d]", j), (j < 2), 1'b1, 1'b0, 1'b0,
                 mk(1'b1, 0, 0, 0, (j == 2) || (j == 3), edges));

        edge_run("freeze", 1'b1, -1, 3, 3);

        for (int j = 0; j < 4; j++)
            tick($sformatf("wait_lo[%0d]", j), 1'b0, 1'b1, 1'b0, 1'b0,
                 mk(1'b1, 1, 0, 0, (j >= 2), edges));
        edges = 0;
        tick("reset_mid", 1'b0, 1'b1, 1'b0, 1'b1, mk(1'b1, 0, 0, 0, 0, 0));
        for (int j = 0; j < 8; j++)
            tick($sformatf("post_reset[%0d]", j), 1'b0, 1'b1, 1'b0, 1'b0,
                 mk(1'b1, 0, 0, 0, 0, 0));

        for (int j = 0; j < 20; j++)
            tick($sformatf("toggle[%0d]", j), (j % 2 == 0), 1'b1, 1'b0, 1'b0,
                 mk(1'b1, 0, 0, 0, (j >= 2) && (j % 2 == 0), 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
